// File: rtl/cart_rom_fetch.sv
`default_nettype none
// ============================================================================
// Module      : cart_rom_fetch
// Description : Cartridge ROM halfword source with one-word prefetch buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module cart_rom_fetch #(
    parameter logic [31:0] ROM_BASE      = 32'h1000_0000,
    parameter int          ROM_SIZE_LOG2 = 26,
    parameter bit          BYTE_SWAP     = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              bus_addr,
    input  logic                     addr_load,
    input  logic                     rd_done,
    output logic [15:0]              data,
    output logic                     data_valid,
    output logic                     underrun,
    output logic                     mem_req,
    output logic [ROM_SIZE_LOG2-3:0] mem_addr,
    input  logic                     mem_ack,
    input  logic                     mem_rvalid,
    input  logic [31:0]              mem_rdata
);
    localparam int c_PTR_W  = ROM_SIZE_LOG2 - 1;
    localparam int c_WORD_W = ROM_SIZE_LOG2 - 2;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = {{(c_PTR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t                r_state_q,    w_state_d;
    logic [c_PTR_W-1:0]    r_ptr_q,      w_ptr_d;
    logic [31:0]           r_cur_word_q, w_cur_word_d;
    logic                  r_cur_v_q,    w_cur_v_d;
    logic [31:0]           r_nxt_word_q, w_nxt_word_d;
    logic                  r_nxt_v_q,    w_nxt_v_d;
    logic                  r_stale_q,    w_stale_d;
    logic                  r_fill_nxt_q, w_fill_nxt_d;
    logic                  r_oor_q,      w_oor_d;
    logic                  r_act_q,      w_act_d;
    logic                  r_underrun_q, w_underrun_d;
    logic [15:0]           r_data_q,     w_data_d;
    logic                  r_data_valid_q, w_data_valid_d;
    logic                  r_mem_req_q,  w_mem_req_d;
    logic [c_WORD_W-1:0]   r_mem_addr_q, w_mem_addr_d;

    logic w_in_range;
    logic w_accepted;
    logic w_need;
    logic w_unused_bit;

    assign w_in_range   = (bus_addr[31:ROM_SIZE_LOG2] == ROM_BASE[31:ROM_SIZE_LOG2]);
    assign w_accepted   = (r_state_q == S_REQ) && mem_ack;
    assign w_unused_bit = bus_addr[0];

    function automatic logic [15:0] f_pick(input logic [31:0] word, input logic lo);
        logic [15:0] h;
        h = lo ? word[15:0] : word[31:16];
        return BYTE_SWAP ? {h[7:0], h[15:8]} : h;
    endfunction

    always_comb begin
        w_state_d      = r_state_q;
        w_ptr_d        = r_ptr_q;
        w_cur_word_d   = r_cur_word_q;
        w_cur_v_d      = r_cur_v_q;
        w_nxt_word_d   = r_nxt_word_q;
        w_nxt_v_d      = r_nxt_v_q;
        w_stale_d      = r_stale_q;
        w_fill_nxt_d   = r_fill_nxt_q;
        w_oor_d        = r_oor_q;
        w_act_d        = r_act_q;
        w_underrun_d   = r_underrun_q;
        w_mem_addr_d   = r_mem_addr_q;
        w_need         = 1'b0;

        // Response lands first so a same-cycle shift can move it into CUR.
        if ((r_state_q == S_WAIT) && mem_rvalid) begin
            if (!r_stale_q) begin
                if (r_fill_nxt_q) begin
                    w_nxt_word_d = mem_rdata;
                    w_nxt_v_d    = 1'b1;
                end else begin
                    w_cur_word_d = mem_rdata;
                    w_cur_v_d    = 1'b1;
                end
            end
            w_stale_d = 1'b0;
            w_state_d = S_IDLE;
        end else if (w_accepted) begin
            w_state_d = S_WAIT;
        end

        if (addr_load) begin
            w_ptr_d      = bus_addr[ROM_SIZE_LOG2-1:1];
            w_cur_v_d    = 1'b0;
            w_nxt_v_d    = 1'b0;
            w_underrun_d = 1'b0;
            w_oor_d      = !w_in_range;
            w_act_d      = w_in_range;
            if (w_state_d == S_WAIT) begin
                w_stale_d = 1'b1;
            end else if ((w_state_d == S_REQ) && !w_in_range) begin
                w_state_d = S_IDLE;
            end
        end else if (rd_done) begin
            if (!r_data_valid_q) begin
                w_underrun_d = 1'b1;
            end
            w_ptr_d = r_ptr_q + c_PTR_ONE;
            if (r_ptr_q[0]) begin
                w_cur_word_d = w_nxt_word_d;
                w_cur_v_d    = w_nxt_v_d;
                w_nxt_v_d    = 1'b0;
                // An in-flight NXT fetch now belongs to CUR; an in-flight CUR
                // fetch is for a word we just walked past.
                if (w_state_d == S_WAIT) begin
                    if (w_fill_nxt_d) begin
                        w_fill_nxt_d = 1'b0;
                    end else begin
                        w_stale_d = 1'b1;
                    end
                end
            end
        end

        w_need = w_act_d && (!w_cur_v_d || !w_nxt_v_d);
        if ((w_state_d == S_IDLE) && w_need) begin
            w_state_d = S_REQ;
        end
        // Address and target track the buffer until the controller accepts.
        if (w_state_d == S_REQ) begin
            w_fill_nxt_d = w_cur_v_d;
            w_mem_addr_d = w_ptr_d[c_PTR_W-1:1] + {{(c_WORD_W-1){1'b0}}, w_cur_v_d};
        end

        w_mem_req_d    = (w_state_d == S_REQ);
        w_data_d       = w_cur_v_d ? f_pick(w_cur_word_d, w_ptr_d[0]) : 16'h0000;
        w_data_valid_d = w_oor_d | w_cur_v_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= S_IDLE;
            r_ptr_q        <= '0;
            r_cur_word_q   <= '0;
            r_cur_v_q      <= 1'b0;
            r_nxt_word_q   <= '0;
            r_nxt_v_q      <= 1'b0;
            r_stale_q      <= 1'b0;
            r_fill_nxt_q   <= 1'b0;
            r_oor_q        <= 1'b0;
            r_act_q        <= 1'b0;
            r_underrun_q   <= 1'b0;
            r_data_q       <= 16'h0000;
            r_data_valid_q <= 1'b0;
            r_mem_req_q    <= 1'b0;
            r_mem_addr_q   <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_ptr_q        <= w_ptr_d;
            r_cur_word_q   <= w_cur_word_d;
            r_cur_v_q      <= w_cur_v_d;
            r_nxt_word_q   <= w_nxt_word_d;
            r_nxt_v_q      <= w_nxt_v_d;
            r_stale_q      <= w_stale_d;
            r_fill_nxt_q   <= w_fill_nxt_d;
            r_oor_q        <= w_oor_d;
            r_act_q        <= w_act_d;
            r_underrun_q   <= w_underrun_d;
            r_data_q       <= w_data_d;
            r_data_valid_q <= w_data_valid_d;
            r_mem_req_q    <= w_mem_req_d;
            r_mem_addr_q   <= w_mem_addr_d;
        end
    end

    assign data       = r_data_q;
    assign data_valid = r_data_valid_q;
    assign underrun   = r_underrun_q;
    assign mem_req    = r_mem_req_q;
    assign mem_addr   = r_mem_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_cart_rom_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_cart_rom_fetch
// Description : Directed and randomized bench for cart_rom_fetch with a
//               halfword-pointer reference model and a latency-driven memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cart_rom_fetch;
    localparam logic [31:0] ROM_BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] bus_addr = '0;
    logic        addr_load = 1'b0;
    logic        rd_done = 1'b0;
    logic [15:0] data;
    logic        data_valid;
    logic        underrun;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    cart_rom_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .bus_addr   (bus_addr),
        .addr_load  (addr_load),
        .rd_done    (rd_done),
        .data       (data),
        .data_valid (data_valid),
        .underrun   (underrun),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // memory controller model
    int          lat = 3;
    int          ack_pct = 100;
    bit          stall = 1'b0;
    bit          spurious = 1'b0;
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [23:0] paddr = '0;
    int          rv_cnt = 0;

    // reference model: the halfword the bus should see is ROM[ptr]
    logic [24:0] m_ptr = '0;
    bit          m_oor = 1'b0;
    bit          m_under = 1'b0;

    function automatic logic [31:0] rom_word(input logic [23:0] a);
        logic [15:0] h;
        if (a == 24'h10) return 32'hAABB_CCDD;
        h = a[15:0] * 16'd7 + 16'h1234;
        return {h, ~h ^ {8'h00, a[23:16]}};
    endfunction

    function automatic logic [15:0] exp_hw(input logic [24:0] p);
        logic [31:0] w;
        w = rom_word(p[24:1]);
        return p[0] ? w[15:0] : w[31:16];
    endfunction

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = $urandom;
        case ($urandom_range(7))
            0: if (a[31:26] == 6'h04) a[31] = 1'b1;
            1: a = {6'h04, 20'hFFFFF, a[5:0]};
            default: a[31:26] = 6'h04;
        endcase
        return a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        bit          acc;
        bit          hit;
        logic [23:0] a_s;
        logic [23:0] w;
        hit        = pend && (cnt == 0);
        mem_rvalid = hit || spurious;
        mem_rdata  = hit ? rom_word(paddr) : 32'hDEAD_BEEF;
        mem_ack    = mem_req && !stall && ($urandom_range(99) < ack_pct);
        acc        = mem_ack;
        a_s        = mem_addr;
        chk("one_outstanding", 32'(mem_req && pend), 32'd0);
        if (acc) begin
            w = m_ptr[24:1];
            chk("req_addr_near_ptr", 32'((a_s == w) || (a_s == w + 24'd1)), 32'd1);
        end
        @(posedge clk);
        if (rst) begin
            m_ptr = '0; m_oor = 1'b0; m_under = 1'b0;
        end else if (addr_load) begin
            m_ptr   = bus_addr[25:1];
            m_oor   = (bus_addr[31:26] != ROM_BASE[31:26]);
            m_under = 1'b0;
        end else if (rd_done) begin
            m_ptr = m_ptr + 25'd1;
        end
        if (hit) begin
            pend = 1'b0;
            rv_cnt++;
        end else if (pend) begin
            cnt--;
        end
        if (acc) begin
            pend = 1'b1; cnt = lat - 1; paddr = a_s;
        end
        spurious = 1'b0;
        #1;
        addr_load = 1'b0; rd_done = 1'b0; mem_ack = 1'b0; mem_rvalid = 1'b0;
        if (m_oor) begin
            chk("oor_data", 32'(data), 32'd0);
            chk("oor_valid", 32'(data_valid), 32'd1);
            chk("oor_no_req", 32'(mem_req), 32'd0);
        end else if (data_valid) begin
            chk("data_vs_model", 32'(data), 32'(exp_hw(m_ptr)));
        end
        chk("underrun_vs_model", 32'(underrun), 32'(m_under));
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!data_valid && n < 40) begin cycle(); n++; end
        chk(tag, 32'(data_valid), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((pend || mem_req) && n < 60) begin cycle(); n++; end
        chk("drain_timeout", 32'(pend || mem_req), 32'd0);
    endtask

    task automatic load(input logic [31:0] a);
        bus_addr = a; addr_load = 1'b1;
        cycle();
    endtask

    initial begin
        int          n;
        int          rv_before;
        logic [31:0] w32;

        // reset values
        rst = 1'b1;
        cycle(); cycle();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_data_valid", 32'(data_valid), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        rst = 1'b0;
        cycle();
        chk("idle_no_req", 32'(mem_req), 32'd0);

        // first fetch, 3-cycle latency
        lat = 3;
        load(32'h1000_0040);
        chk("t1_req", 32'(mem_req), 32'd1);
        chk("t1_addr", 32'(mem_addr), 32'h10);
        chk("t1_dv_low", 32'(data_valid), 32'd0);
        cycle(); cycle(); cycle();
        chk("t1_dv_before_resp", 32'(data_valid), 32'd0);
        cycle();
        chk("t1_data", 32'(data), 32'hAABB);
        chk("t1_dv", 32'(data_valid), 32'd1);
        chk("t1_prefetch_req", 32'(mem_req), 32'd1);
        chk("t1_prefetch_addr", 32'(mem_addr), 32'h11);
        rd_done = 1'b1;
        cycle();
        chk("t1_second_half", 32'(data), 32'hCCDD);
        drain();

        // sequential burst, latency 2
        lat = 2;
        load(32'h1000_0200);
        wait_valid("burst_first_valid");
        for (int i = 0; i < 8; i++) begin
            rd_done = 1'b1;
            cycle();
            chk("burst_no_bubble", 32'(data_valid), 32'd1);
            for (int j = 0; j < 4; j++) begin
                cycle();
                chk("burst_no_bubble", 32'(data_valid), 32'd1);
            end
        end
        chk("burst_ptr_data", 32'(data), 32'(exp_hw(25'h108)));
        drain();

        // address reload while a request is outstanding
        lat = 4;
        load(32'h1000_0500);
        chk("stale_first_addr", 32'(mem_addr), 32'h140);
        cycle();
        rv_before = rv_cnt;
        load(32'h1000_0100);
        n = 0;
        while (!mem_req && n < 20) begin cycle(); n++; end
        chk("stale_resp_before_new_req", 32'(rv_cnt > rv_before), 32'd1);
        chk("stale_new_addr", 32'(mem_addr), 32'h40);
        wait_valid("stale_new_valid");
        w32 = rom_word(24'h40);
        chk("stale_new_data", 32'(data), 32'(w32[31:16]));
        drain();

        // out of range
        load(32'h0500_0000);
        chk("oor_req_t1", 32'(mem_req), 32'd0);
        rd_done = 1'b1;
        cycle(); cycle(); cycle();
        chk("oor_still_valid", 32'(data_valid), 32'd1);

        // wrap at top of ROM
        lat = 2;
        load(32'h13FF_FFFC);
        chk("wrap_first_addr", 32'(mem_addr), 32'hFF_FFFF);
        wait_valid("wrap_valid");
        chk("wrap_prefetch_req", 32'(mem_req), 32'd1);
        chk("wrap_prefetch_addr", 32'(mem_addr), 32'h0);
        n = 0;
        while (mem_req && n < 20) begin cycle(); n++; end
        cycle();
        rd_done = 1'b1; cycle();
        rd_done = 1'b1; cycle();
        chk("wrap_word0_valid", 32'(data_valid), 32'd1);
        chk("wrap_word0_data", 32'(data), 32'(exp_hw(25'h0)));
        drain();

        // underrun with a stalled memory
        stall = 1'b1;
        load(32'h1000_0080);
        chk("ur_dv_low", 32'(data_valid), 32'd0);
        rd_done = 1'b1; m_under = 1'b1;
        cycle();
        chk("ur_set", 32'(underrun), 32'd1);
        cycle(); cycle();
        chk("ur_sticky", 32'(underrun), 32'd1);
        stall = 1'b0;
        wait_valid("ur_recover_valid");
        chk("ur_ptr_advanced", 32'(data), 32'(exp_hw(25'h41)));
        stall = 1'b1;
        bus_addr = 32'h1000_0090; addr_load = 1'b1; rd_done = 1'b1;
        cycle();
        chk("ur_cleared", 32'(underrun), 32'd0);
        chk("readdr_req", 32'(mem_req), 32'd1);
        chk("readdr_addr", 32'(mem_addr), 32'h24);
        stall = 1'b0;
        wait_valid("load_wins_valid");
        chk("load_wins_data", 32'(data), 32'(exp_hw(25'h48)));
        drain();

        // stray rvalid with nothing outstanding
        spurious = 1'b1;
        cycle(); cycle();
        chk("spurious_ignored", 32'(data), 32'(exp_hw(25'h48)));

        // reset mid-transaction, late response ignored
        lat = 4;
        load(32'h1000_0300);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n = 0;
        while (pend && n < 10) begin
            cycle(); n++;
            chk("rst_abandon_dv", 32'(data_valid), 32'd0);
            chk("rst_abandon_req", 32'(mem_req), 32'd0);
        end
        cycle();
        chk("rst_abandon_final_dv", 32'(data_valid), 32'd0);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            int r;
            if (i % 100 == 0) ack_pct = $urandom_range(30, 100);
            lat = $urandom_range(1, 4);
            r = $urandom_range(99);
            if (r < 4) begin
                bus_addr  = rnd_addr();
                addr_load = 1'b1;
                if ($urandom_range(3) == 0 && data_valid) rd_done = 1'b1;
            end else if (data_valid && r < 50) begin
                rd_done = 1'b1;
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
